// File: rtl/axi_burst_pkg.sv
// axi_burst_pkg: shared FSM encoding, AXI field constants and sizing helpers
package axi_burst_pkg;
  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, NEXT} state_e;
  localparam logic [1:0] ABURST_INCR = 2'b01;
  localparam logic ATYPE_WR = 1'b1;
  localparam logic ATYPE_RD = 1'b0;
  function automatic logic [2:0] asize(input int data_w);
    return 3'($clog2(data_w / 8));
  endfunction
  function automatic int ptr_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/axi_burst_wr_verify_if.sv
// axi_burst_wr_verify_if: DDR port 0 shared-address AXI channels
interface axi_burst_wr_verify_if #(parameter int DATA_W = 256, parameter int ADDR_W = 32);
  logic [7:0] DDR_AID_0;
  logic [ADDR_W-1:0] DDR_AADDR_0;
  logic [7:0] DDR_ALEN_0;
  logic [2:0] DDR_ASIZE_0;
  logic [1:0] DDR_ABURST_0;
  logic [1:0] DDR_ALOCK_0;
  logic DDR_ATYPE_0, DDR_AVALID_0, DDR_AREADY_0;
  logic [7:0] DDR_WID_0;
  logic [DATA_W-1:0] DDR_WDATA_0;
  logic [DATA_W/8-1:0] DDR_WSTRB_0;
  logic DDR_WLAST_0, DDR_WVALID_0, DDR_WREADY_0;
  logic [7:0] DDR_BID_0;
  logic DDR_BVALID_0, DDR_BREADY_0;
  logic [7:0] DDR_RID_0;
  logic [DATA_W-1:0] DDR_RDATA_0;
  logic [1:0] DDR_RRESP_0;
  logic DDR_RLAST_0, DDR_RVALID_0, DDR_RREADY_0;
  modport master (
    output DDR_AID_0, DDR_AADDR_0, DDR_ALEN_0, DDR_ASIZE_0, DDR_ABURST_0, DDR_ALOCK_0, DDR_ATYPE_0, DDR_AVALID_0,
    output DDR_WID_0, DDR_WDATA_0, DDR_WSTRB_0, DDR_WLAST_0, DDR_WVALID_0, DDR_BREADY_0, DDR_RREADY_0,
    input DDR_AREADY_0, DDR_WREADY_0, DDR_BID_0, DDR_BVALID_0,
    input DDR_RID_0, DDR_RDATA_0, DDR_RRESP_0, DDR_RLAST_0, DDR_RVALID_0
  );
  modport slave (
    input DDR_AID_0, DDR_AADDR_0, DDR_ALEN_0, DDR_ASIZE_0, DDR_ABURST_0, DDR_ALOCK_0, DDR_ATYPE_0, DDR_AVALID_0,
    input DDR_WID_0, DDR_WDATA_0, DDR_WSTRB_0, DDR_WLAST_0, DDR_WVALID_0, DDR_BREADY_0, DDR_RREADY_0,
    output DDR_AREADY_0, DDR_WREADY_0, DDR_BID_0, DDR_BVALID_0,
    output DDR_RID_0, DDR_RDATA_0, DDR_RRESP_0, DDR_RLAST_0, DDR_RVALID_0
  );
endinterface

// File: rtl/axi_burst_wr_verify_beat_buffer.sv
// axi_beat_buffer: holds one written burst for beat-by-beat read-back comparison
module axi_beat_buffer import axi_burst_pkg::*; #(
  parameter int DATA_W = 256,
  parameter int BURST_LEN = 4,
  localparam int PW = ptr_w(BURST_LEN)
) (
  input  logic clk,
  input  logic rst,
  input  logic we_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [PW-1:0] rptr_i,
  output logic [PW-1:0] wptr_o,
  output logic [DATA_W-1:0] rdata_o
);
  localparam logic [PW-1:0] LAST = PW'(BURST_LEN - 1);
  logic [DATA_W-1:0] mem_q [BURST_LEN];
  logic [PW-1:0] wptr_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) wptr_q <= '0;
    else if (we_i) wptr_q <= wptr_q == LAST ? '0 : wptr_q + PW'(1);
  always_ff @(posedge clk)
    if (we_i) mem_q[wptr_q] <= wdata_i;
  assign wptr_o = wptr_q;
  assign rdata_o = mem_q[rptr_i];
endmodule

// File: rtl/axi_burst_wr_verify.sv
// axi_burst_wr_verify: FWFT FIFO to AXI burst writer with optional read-back compare
module axi_burst_wr_verify import axi_burst_pkg::*; #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 32,
  parameter int BURST_LEN = 4,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [ADDR_W-1:0] STOP_ADDR = ADDR_W'(32'h0010_0000),
  parameter logic [7:0] AXI_ID = 8'h00,
  parameter bit VERIFY = 1'b1
) (
  input  logic axi_clk,
  input  logic rst,
  input  logic TRIGGER,
  input  logic i_pause,
  input  logic [DATA_W-1:0] data_in,
  input  logic check_empty,
  output logic read_enable,
  axi_burst_wr_verify_if.master ddr,
  output logic o_busy,
  output logic o_done,
  output logic o_compare_error,
  output logic [ADDR_W-1:0] o_error_addr
);
  localparam int PW = ptr_w(BURST_LEN);
  localparam logic [PW-1:0] LAST = PW'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(DATA_W / 8);
  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * DATA_W / 8);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, err_addr_q, next_addr;
  logic done_q, err_q;
  logic [PW-1:0] rbeat_q, wbeat;
  logic [DATA_W-1:0] buf_rdata;
  logic w_hs, r_hs, b_ok, r_bad, last_wr, last_rd;
  assign w_hs = state_q == WR_DATA && !check_empty && ddr.DDR_WREADY_0;
  assign r_hs = state_q == RD_DATA && ddr.DDR_RVALID_0;
  assign b_ok = ddr.DDR_BVALID_0 && ddr.DDR_BID_0 == AXI_ID;
  assign last_wr = wbeat == LAST;
  assign last_rd = rbeat_q == LAST;
  assign next_addr = cur_addr_q + BURST_BYTES;
  // RID is checked alongside RRESP since port 0 is shared
  assign r_bad = ddr.DDR_RDATA_0 != buf_rdata || ddr.DDR_RRESP_0 != 2'b00 ||
                 ddr.DDR_RLAST_0 != last_rd || ddr.DDR_RID_0 != AXI_ID;
  axi_beat_buffer #(.DATA_W(DATA_W), .BURST_LEN(BURST_LEN)) u_buf (
    .clk(axi_clk), .rst(rst), .we_i(w_hs), .wdata_i(data_in),
    .rptr_i(rbeat_q), .wptr_o(wbeat), .rdata_o(buf_rdata)
  );
  always_ff @(posedge axi_clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (TRIGGER && !i_pause && !check_empty) state_d = WR_ADDR;
      WR_ADDR: if (ddr.DDR_AREADY_0) state_d = WR_DATA;
      WR_DATA: if (w_hs && last_wr) state_d = WR_RESP;
      WR_RESP: if (b_ok) state_d = VERIFY ? RD_ADDR : NEXT;
      RD_ADDR: if (ddr.DDR_AREADY_0) state_d = RD_DATA;
      RD_DATA: if (r_hs && last_rd) state_d = NEXT;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    o_busy = state_q != IDLE;
    ddr.DDR_AID_0 = o_busy ? AXI_ID : 8'h00;
    ddr.DDR_WID_0 = o_busy ? AXI_ID : 8'h00;
    ddr.DDR_AADDR_0 = cur_addr_q;
    ddr.DDR_ALEN_0 = o_busy ? 8'(BURST_LEN - 1) : 8'h00;
    ddr.DDR_ASIZE_0 = o_busy ? asize(DATA_W) : 3'd0;
    ddr.DDR_ABURST_0 = o_busy ? ABURST_INCR : 2'b00;
    ddr.DDR_ALOCK_0 = 2'b00;
    ddr.DDR_ATYPE_0 = state_q inside {WR_ADDR, WR_DATA, WR_RESP} ? ATYPE_WR : ATYPE_RD;
    ddr.DDR_AVALID_0 = state_q inside {WR_ADDR, RD_ADDR};
    ddr.DDR_WVALID_0 = state_q == WR_DATA && !check_empty;
    ddr.DDR_WDATA_0 = state_q == WR_DATA ? data_in : '0;
    ddr.DDR_WSTRB_0 = '1;
    ddr.DDR_WLAST_0 = state_q == WR_DATA && last_wr;
    ddr.DDR_BREADY_0 = state_q == WR_RESP;
    ddr.DDR_RREADY_0 = state_q == RD_DATA;
    read_enable = w_hs;
  end
  always_ff @(posedge axi_clk or posedge rst)
    if (rst) begin
      cur_addr_q <= START_ADDR;
      done_q <= 1'b0;
      err_q <= 1'b0;
      err_addr_q <= '0;
      rbeat_q <= '0;
    end else begin
      done_q <= state_q == NEXT && next_addr == STOP_ADDR;
      if (state_q == NEXT) cur_addr_q <= next_addr == STOP_ADDR ? START_ADDR : next_addr;
      if (r_hs) rbeat_q <= last_rd ? '0 : rbeat_q + PW'(1);
      if (state_q == IDLE && state_d == WR_ADDR && cur_addr_q == START_ADDR) err_q <= 1'b0;
      else if (r_hs && r_bad) begin
        err_q <= 1'b1;
        if (!err_q) err_addr_q <= cur_addr_q + ADDR_W'(rbeat_q) * BEAT_BYTES;
      end
    end
  assign o_done = done_q;
  assign o_compare_error = err_q;
  assign o_error_addr = err_addr_q;
endmodule

// File: tb/tb_axi_burst_wr_verify.sv
// tb_axi_burst_wr_verify: randomized scoreboard bench with FIFO and AXI memory models
module tb_axi_burst_wr_verify;
  localparam int DW = 256;
  localparam int AW = 32;
  localparam int BL = 4;
  localparam logic [31:0] START = 32'h0;
  localparam logic [31:0] STOP = 32'h100;
  localparam logic [31:0] BB = BL * DW / 8;
  typedef struct { logic [31:0] addr; logic [DW-1:0] data; logic last; } beat_t;

  logic clk = 1'b0, rst = 1'b1, trig = 1'b0, pause = 1'b0, empty, ren;
  logic [DW-1:0] din;
  logic busy, done, cerr;
  logic [AW-1:0] eaddr;
  axi_burst_wr_verify_if #(.DATA_W(DW), .ADDR_W(AW)) ddr ();
  axi_burst_wr_verify #(.DATA_W(DW), .ADDR_W(AW), .BURST_LEN(BL), .START_ADDR(START), .STOP_ADDR(STOP),
    .AXI_ID(8'h00), .VERIFY(1'b1)) dut (
    .axi_clk(clk), .rst(rst), .TRIGGER(trig), .i_pause(pause), .data_in(din), .check_empty(empty),
    .read_enable(ren), .ddr(ddr), .o_busy(busy), .o_done(done), .o_compare_error(cerr), .o_error_addr(eaddr));
  always #5 clk = ~clk;

  beat_t exp_w[$];
  logic [31:0] exp_rd[$];
  logic [DW-1:0] fifo[$];
  logic [DW-1:0] mem [logic [31:0]];
  int total = 0, bad = 0, widx = 0, pushed = 0, pops = 0, dones = 0, exp_done = 0;
  bit rand_rdy = 0, starve = 0, corrupt = 0;
  bit aw_f, w_f, b_f, r_f, pop_f, atype_f, wlast_f;
  logic [31:0] aaddr_f;
  logic [DW-1:0] wdata_f;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // reference model: word n lands at window offset (n/BL)*BB, beat n%BL
  task automatic push(input int n);
    logic [DW-1:0] d;
    beat_t e;
    int burst;
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) begin
      d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      burst = widx / BL;
      e.addr = START + (32'(burst) * BB) % (STOP - START) + 32'(widx % BL) * 32;
      e.data = d;
      e.last = (widx % BL) == BL - 1;
      fifo.push_back(d);
      exp_w.push_back(e);
      if (e.last) begin
        exp_rd.push_back(e.addr - 32'((BL - 1) * 32));
        if ((32'(burst + 1) * BB) % (STOP - START) == 0) exp_done++;
      end
      widx++;
      pushed++;
    end
  endtask

  task automatic drain(input string name);
    bit ok = 0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk);
      ok = exp_w.size() == 0 && exp_rd.size() == 0 && !busy && fifo.size() == 0;
    end
    chk({name, "_drain"}, ok, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_avalid"}, ddr.DDR_AVALID_0, 0);
    chk({p, "_wvalid"}, ddr.DDR_WVALID_0, 0);
    chk({p, "_wlast"}, ddr.DDR_WLAST_0, 0);
    chk({p, "_bready"}, ddr.DDR_BREADY_0, 0);
    chk({p, "_rready"}, ddr.DDR_RREADY_0, 0);
    chk({p, "_pop"}, ren, 0);
    chk({p, "_aaddr"}, ddr.DDR_AADDR_0, START);
    chk({p, "_alen"}, ddr.DDR_ALEN_0, 0);
    chk({p, "_asize"}, ddr.DDR_ASIZE_0, 0);
    chk({p, "_aburst"}, ddr.DDR_ABURST_0, 0);
    chk({p, "_atype"}, ddr.DDR_ATYPE_0, 0);
    chk({p, "_aid"}, ddr.DDR_AID_0, 0);
    chk({p, "_wid"}, ddr.DDR_WID_0, 0);
    chk({p, "_wdata"}, ddr.DDR_WDATA_0, 0);
    chk({p, "_wstrb"}, ddr.DDR_WSTRB_0, 32'hffff_ffff);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_done"}, done, 0);
    chk({p, "_err"}, cerr, 0);
    chk({p, "_eaddr"}, eaddr, 0);
  endtask

  // monitor: handshakes seen here complete on the following rising edge
  always @(negedge clk) begin
    aw_f = 0; w_f = 0; b_f = 0; r_f = 0; pop_f = 0;
    if (!rst) begin
      aw_f = ddr.DDR_AVALID_0 && ddr.DDR_AREADY_0;
      aaddr_f = ddr.DDR_AADDR_0;
      atype_f = ddr.DDR_ATYPE_0;
      w_f = ddr.DDR_WVALID_0 && ddr.DDR_WREADY_0;
      wdata_f = ddr.DDR_WDATA_0;
      wlast_f = ddr.DDR_WLAST_0;
      b_f = ddr.DDR_BVALID_0 && ddr.DDR_BREADY_0;
      r_f = ddr.DDR_RVALID_0 && ddr.DDR_RREADY_0;
      pop_f = ren;
      if (done) dones++;
      if (ren) pops++;
      if (empty) chk("pop_while_empty", ren, 0);
      if (aw_f && atype_f) begin
        chk("aw_expected", exp_w.size() != 0, 1);
        if (exp_w.size() != 0) begin
          chk("aw_addr", aaddr_f, exp_w[0].addr);
          chk("aw_alen", ddr.DDR_ALEN_0, BL - 1);
          chk("aw_asize", ddr.DDR_ASIZE_0, 5);
          chk("aw_aburst", ddr.DDR_ABURST_0, 1);
        end
      end
      if (aw_f && !atype_f) begin
        chk("ar_expected", exp_rd.size() != 0, 1);
        if (exp_rd.size() != 0) chk("ar_addr", aaddr_f, exp_rd.pop_front());
      end
      if (w_f) begin
        chk("w_expected", exp_w.size() != 0, 1);
        if (exp_w.size() != 0) begin
          chk("wdata", wdata_f, exp_w[0].data);
          chk("wlast", wlast_f, exp_w[0].last);
          chk("wstrb", ddr.DDR_WSTRB_0, 32'hffff_ffff);
          void'(exp_w.pop_front());
        end
      end
    end
  end

  // FIFO and AXI memory slave driver
  initial begin
    int wr_cnt = 0, rd_cnt = 0, b_pend = 0;
    bit rd_active = 0;
    logic [31:0] wr_base = 0, rd_base = 0;
    logic [DW-1:0] rw;
    ddr.DDR_AREADY_0 = 0; ddr.DDR_WREADY_0 = 0; ddr.DDR_BVALID_0 = 0; ddr.DDR_BID_0 = 0;
    ddr.DDR_RVALID_0 = 0; ddr.DDR_RID_0 = 0; ddr.DDR_RDATA_0 = '0; ddr.DDR_RRESP_0 = 0; ddr.DDR_RLAST_0 = 0;
    din = '0; empty = 1;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        ddr.DDR_AREADY_0 = 0; ddr.DDR_WREADY_0 = 0; ddr.DDR_BVALID_0 = 0;
        ddr.DDR_RVALID_0 = 0; ddr.DDR_RLAST_0 = 0;
        b_pend = 0; rd_active = 0; wr_cnt = 0; rd_cnt = 0;
      end else begin
        if (pop_f && fifo.size() > 0) void'(fifo.pop_front());
        if (aw_f && atype_f) begin wr_base = aaddr_f; wr_cnt = 0; end
        if (aw_f && !atype_f) begin rd_base = aaddr_f; rd_cnt = 0; rd_active = 1; end
        if (w_f) begin
          mem[wr_base + 32'(wr_cnt) * 32] = wdata_f;
          wr_cnt++;
          if (wlast_f) b_pend++;
        end
        if (b_f) ddr.DDR_BVALID_0 = 0;
        if (!ddr.DDR_BVALID_0 && b_pend > 0 && $urandom_range(0, 2) == 0) begin
          ddr.DDR_BVALID_0 = 1;
          b_pend--;
        end
        if (r_f) begin
          rd_cnt++;
          if (rd_cnt == BL) rd_active = 0;
        end
        if (r_f || !ddr.DDR_RVALID_0) begin
          rw = rd_active && mem.exists(rd_base + 32'(rd_cnt) * 32) ? mem[rd_base + 32'(rd_cnt) * 32] : '0;
          if (corrupt && rd_cnt == 2) rw[0] = ~rw[0];
          ddr.DDR_RVALID_0 = rd_active && $urandom_range(0, 3) != 0;
          ddr.DDR_RDATA_0 = rw;
          ddr.DDR_RLAST_0 = rd_cnt == BL - 1;
        end
        ddr.DDR_AREADY_0 = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        ddr.DDR_WREADY_0 = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      #1;
      din = fifo.size() > 0 ? fifo[0] : '0;
      empty = fifo.size() == 0 || starve;
    end
  end

  initial begin
    bit ok;
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("rst");
    @(posedge clk); #3; rst = 0;
    trig = 1;
    push(8);
    drain("p1");
    chk("p1_pops", pops, pushed);
    chk("p1_err", cerr, 0);
    chk("p1_done", dones, exp_done);

    corrupt = 1;
    push(8);
    drain("p2");
    corrupt = 0;
    chk("p2_err", cerr, 1);
    chk("p2_eaddr", eaddr, 32'h40);
    chk("p2_done", dones, exp_done);

    rand_rdy = 1;
    push(2);
    repeat (40) @(negedge clk);
    chk("p3_partial_pops", pops, pushed);
    chk("p3_stalled", busy, 1);
    chk("p3_wvalid_low", ddr.DDR_WVALID_0, 0);
    chk("p3_err_cleared", cerr, 0);
    push(2);
    drain("p3");
    chk("p3_pops", pops, pushed);

    rand_rdy = 0;
    push(8);
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin @(negedge clk); ok = exp_w.size() < 8; end
    chk("p4_started", ok, 1);
    @(posedge clk); #1; pause = 1;
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin @(negedge clk); ok = !busy; end
    chk("p4_burst_end", ok, 1);
    repeat (20) @(negedge clk);
    chk("p4_one_burst", exp_w.size(), 4);
    chk("p4_held_idle", busy, 0);
    @(posedge clk); #1; pause = 0;
    drain("p4");

    rand_rdy = 1;
    for (int k = 0; k < 40; k += n) begin
      n = $urandom_range(1, 3);
      if (k + n > 40) n = 40 - k;
      push(n);
      starve = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 6)) @(posedge clk);
    end
    @(posedge clk); #1; starve = 0;
    drain("p5");
    chk("p5_pops", pops, pushed);
    chk("p5_err", cerr, 0);
    chk("p5_done", dones, exp_done);

    rand_rdy = 0;
    push(2);
    repeat (10) @(negedge clk);
    chk("p6_stalled", busy, 1);
    @(posedge clk); #3; rst = 1;
    #1;
    chk_reset("midrst");
    @(negedge clk);
    fifo.delete(); exp_w.delete(); exp_rd.delete();
    widx = 0;
    @(posedge clk); #3; rst = 0;
    push(4);
    drain("p6");
    chk("p6_pops", pops, pushed);
    chk("p6_err", cerr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
